// File: rtl/micro_op_decoder_if.sv
// -----------------------------------------------------------------------------
// micro_op_decoder_if
//   Bundle between the microsequencer and the micro-op decoder.
//   The sequencer drives the micro-op address (mir). The decoder returns the
//   stall request and every datapath/memory control strobe.
//
//   Signals:
//     mir        [5:0]  micro-op address (0 idle, 1..56 legal, 57..63 illegal)
//     stall             hold request back to the sequencer
//     bus_sel    [3:0]  bus source select
//     ld_en      [7:0]  one-hot register load (PC,AR,DR,IR,AC,RA,RB,RC)
//     pc_inc            PC increment
//     alu_op     [2:0]  ALU operation
//     z_we              Z flag write enable
//     mem_rd / mem_wr   memory read / write, held for the whole access
//     instr_done        last micro-op of an instruction
//     illegal_op        sticky illegal micro-op flag
//
//   Modports:
//     master  sequencer side (drives mir)
//     slave   decoder side (drives everything else)
// -----------------------------------------------------------------------------
interface micro_op_decoder_if;
    logic [5:0] mir;
    logic       stall;
    logic [3:0] bus_sel;
    logic [7:0] ld_en;
    logic       pc_inc;
    logic [2:0] alu_op;
    logic       z_we;
    logic       mem_rd;
    logic       mem_wr;
    logic       instr_done;
    logic       illegal_op;

    modport master (
        output mir,
        input  stall, bus_sel, ld_en, pc_inc, alu_op, z_we,
               mem_rd, mem_wr, instr_done, illegal_op
    );

    modport slave (
        input  mir,
        output stall, bus_sel, ld_en, pc_inc, alu_op, z_we,
               mem_rd, mem_wr, instr_done, illegal_op
    );
endinterface

// File: rtl/micro_op_decoder.sv
// -----------------------------------------------------------------------------
// micro_op_decoder
//   Consumer end of the microsequencer. It samples the micro-op address each
//   cycle and turns it into registered datapath control strobes, one cycle
//   after the sampling edge. Memory micro-ops are stretched by MEM_LAT wait
//   cycles. During those cycles the decoder holds stall high, and the
//   sequencer holds mir.
//
//   Parameters:
//     MEM_LAT  extra wait cycles per memory micro-op (0..15), 0 = single cycle
//
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     mop    micro_op_decoder_if.slave (mir in, stall + control strobes out)
//
//   Optional feature:
//     MOP_ERR_TRAP_EN  when defined, micro-op addresses 57..63 set a sticky
//                      illegal_op flag and park the decoder in HALT (stall
//                      high, all strobes low) until reset. When undefined,
//                      those addresses decode as idle and illegal_op is 0.
// -----------------------------------------------------------------------------
module micro_op_decoder #(
    parameter int unsigned MEM_LAT = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    micro_op_decoder_if.slave  mop
);

    // Bus source codes
    localparam logic [3:0] BUS_NONE = 4'd0;
    localparam logic [3:0] BUS_PC   = 4'd1;
    localparam logic [3:0] BUS_DR   = 4'd2;
    localparam logic [3:0] BUS_AC   = 4'd3;
    localparam logic [3:0] BUS_RA   = 4'd4;
    localparam logic [3:0] BUS_MEM  = 4'd7;

    // One-hot load enables
    localparam logic [7:0] LD_PC = 8'h01;
    localparam logic [7:0] LD_AR = 8'h02;
    localparam logic [7:0] LD_DR = 8'h04;
    localparam logic [7:0] LD_IR = 8'h08;
    localparam logic [7:0] LD_AC = 8'h10;
    localparam logic [7:0] LD_RA = 8'h20;

    // ALU operations
    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_MUL  = 3'd3;
    localparam logic [2:0] ALU_INC  = 3'd4;
    localparam logic [2:0] ALU_CLR  = 3'd5;

    localparam logic [3:0] LAT_CNT = 4'(MEM_LAT);

    typedef struct packed {
        logic [3:0] bus_sel;
        logic [7:0] ld_en;
        logic       pc_inc;
        logic [2:0] alu_op;
        logic       z_we;
        logic       mem_rd;
        logic       mem_wr;
        logic       instr_done;
    } ctrl_t;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } state_t;

    state_t     state_q;
    logic [3:0] cnt_q;
    logic       stall_q;
    ctrl_t      ctrl_q;     // strobes presented to the datapath
    ctrl_t      held_q;     // full decode of the memory op in flight
    ctrl_t      dec_d;      // combinational decode of mir
    ctrl_t      dec_wait;   // decode with the end-of-access strobes masked
    logic       dec_is_mem;

    // Index (0..2) of RA/RB/RC selects consecutive bus codes and load bits.
    function automatic logic [3:0] rx_bus(input logic [1:0] idx);
        return BUS_RA + {2'b00, idx};
    endfunction

    function automatic logic [7:0] rx_ld(input logic [1:0] idx);
        return LD_RA << idx;
    endfunction

    always_comb begin
        dec_d = '0;
        case (mop.mir) inside
            6'd1, 6'd4, 6'd8, 6'd12, 6'd14, 6'd16, 6'd52: begin
                dec_d.bus_sel = BUS_PC;  dec_d.ld_en = LD_AR;
            end
            6'd2, 6'd5, 6'd9: begin
                dec_d.bus_sel = BUS_MEM; dec_d.ld_en = LD_DR;
                dec_d.pc_inc  = 1'b1;    dec_d.mem_rd = 1'b1;
            end
            6'd3: begin
                dec_d.bus_sel = BUS_DR;  dec_d.ld_en = LD_IR;
            end
            6'd6, 6'd10: begin
                dec_d.bus_sel = BUS_DR;  dec_d.ld_en = LD_AR;
            end
            6'd7: begin
                dec_d.bus_sel = BUS_MEM; dec_d.ld_en = LD_AC; dec_d.mem_rd = 1'b1;
            end
            6'd11: begin
                dec_d.bus_sel = BUS_AC;  dec_d.mem_wr = 1'b1;
            end
            6'd13, 6'd15, 6'd17: begin
                dec_d.bus_sel = BUS_MEM;
                dec_d.ld_en   = rx_ld(2'((mop.mir - 6'd13) >> 1));
                dec_d.pc_inc  = 1'b1;    dec_d.mem_rd = 1'b1;
            end
            6'd18, 6'd27: begin
                dec_d.bus_sel = rx_bus(2'd0); dec_d.ld_en = LD_AR;
            end
            6'd21, 6'd30: begin
                dec_d.bus_sel = rx_bus(2'd1); dec_d.ld_en = LD_AR;
            end
            6'd24, 6'd33: begin
                dec_d.bus_sel = rx_bus(2'd2); dec_d.ld_en = LD_AR;
            end
            6'd19, 6'd22, 6'd25: begin
                dec_d.bus_sel = BUS_MEM; dec_d.ld_en = LD_DR; dec_d.mem_rd = 1'b1;
            end
            6'd20, 6'd23, 6'd26: begin
                dec_d.bus_sel = BUS_DR;  dec_d.ld_en = LD_AC;
            end
            6'd28, 6'd31, 6'd34: begin
                dec_d.bus_sel = BUS_AC;  dec_d.ld_en = LD_DR;
            end
            6'd29, 6'd32, 6'd35: begin
                dec_d.bus_sel = BUS_DR;  dec_d.mem_wr = 1'b1;
            end
            [6'd36:6'd38]: begin
                dec_d.bus_sel = BUS_AC;
                dec_d.ld_en   = rx_ld(2'(mop.mir - 6'd36));
                dec_d.alu_op  = ALU_PASS;
            end
            [6'd39:6'd41]: begin
                dec_d.bus_sel = rx_bus(2'(mop.mir - 6'd39));
                dec_d.ld_en   = LD_AC; dec_d.alu_op = ALU_ADD; dec_d.z_we = 1'b1;
            end
            [6'd42:6'd44]: begin
                // Rx <= Rx + 1: the register is both the source and the destination.
                dec_d.bus_sel = rx_bus(2'(mop.mir - 6'd42));
                dec_d.ld_en   = rx_ld(2'(mop.mir - 6'd42));
                dec_d.alu_op  = ALU_INC; dec_d.z_we = 1'b1;
            end
            [6'd45:6'd47]: begin
                dec_d.bus_sel = rx_bus(2'(mop.mir - 6'd45));
                dec_d.ld_en   = LD_AC; dec_d.alu_op = ALU_SUB; dec_d.z_we = 1'b1;
            end
            6'd48: begin
                dec_d.bus_sel = BUS_AC;  dec_d.ld_en = LD_AC;
                dec_d.alu_op  = ALU_INC; dec_d.z_we  = 1'b1;
            end
            [6'd49:6'd51]: begin
                dec_d.bus_sel = rx_bus(2'(mop.mir - 6'd49));
                dec_d.ld_en   = LD_AC; dec_d.alu_op = ALU_MUL; dec_d.z_we = 1'b1;
            end
            6'd53: begin
                dec_d.bus_sel = BUS_MEM; dec_d.ld_en = LD_PC; dec_d.mem_rd = 1'b1;
            end
            6'd54: begin
                dec_d.pc_inc = 1'b1;
            end
            6'd55: begin
                dec_d.bus_sel = BUS_NONE; dec_d.ld_en = LD_AC;
                dec_d.alu_op  = ALU_CLR;  dec_d.z_we  = 1'b1;
            end
            default: ;  // 0, 56 and 57..63 drive no strobes
        endcase

        dec_d.instr_done = mop.mir inside {6'd7, 6'd11, 6'd13, 6'd15, 6'd17, 6'd20,
                                           6'd23, 6'd26, 6'd29, 6'd32, 6'd35,
                                           [6'd36:6'd51], [6'd53:6'd56]};

        // While the access is pending, only the bus and memory strobes are visible.
        // The load, increment and done strobes are held back for the final cycle.
        dec_wait            = dec_d;
        dec_wait.ld_en      = '0;
        dec_wait.pc_inc     = 1'b0;
        dec_wait.instr_done = 1'b0;
    end

    assign dec_is_mem = dec_d.mem_rd | dec_d.mem_wr;

`ifdef MOP_ERR_TRAP_EN
    logic illegal_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            stall_q <= 1'b0;
            ctrl_q  <= '0;
            held_q  <= '0;
`ifdef MOP_ERR_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_RUN: begin
`ifdef MOP_ERR_TRAP_EN
                    if (mop.mir >= 6'd57) begin
                        state_q   <= ST_HALT;
                        illegal_q <= 1'b1;
                        stall_q   <= 1'b1;
                        ctrl_q    <= '0;
                    end else
`endif
                    if (dec_is_mem && (MEM_LAT != 0)) begin
                        state_q <= ST_MEM_WAIT;
                        cnt_q   <= LAT_CNT;
                        stall_q <= 1'b1;
                        ctrl_q  <= dec_wait;
                        held_q  <= dec_d;
                    end else begin
                        stall_q <= 1'b0;
                        ctrl_q  <= dec_d;
                    end
                end
                ST_MEM_WAIT: begin
                    // mir is ignored here. The sequencer holds it while stall is high.
                    if (cnt_q == 4'd1) begin
                        state_q <= ST_RUN;
                        cnt_q   <= '0;
                        stall_q <= 1'b0;
                        ctrl_q  <= held_q;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_HALT: begin
                    stall_q <= 1'b1;
                    ctrl_q  <= '0;
                end
                default: begin
                    state_q <= ST_RUN;
                    stall_q <= 1'b0;
                    ctrl_q  <= '0;
                end
            endcase
        end
    end

    assign mop.stall      = stall_q;
    assign mop.bus_sel    = ctrl_q.bus_sel;
    assign mop.ld_en      = ctrl_q.ld_en;
    assign mop.pc_inc     = ctrl_q.pc_inc;
    assign mop.alu_op     = ctrl_q.alu_op;
    assign mop.z_we       = ctrl_q.z_we;
    assign mop.mem_rd     = ctrl_q.mem_rd;
    assign mop.mem_wr     = ctrl_q.mem_wr;
    assign mop.instr_done = ctrl_q.instr_done;
`ifdef MOP_ERR_TRAP_EN
    assign mop.illegal_op = illegal_q;
`else
    assign mop.illegal_op = 1'b0;
`endif

endmodule
